mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared read/write port of the 256x8 data RAM. It accepts read/write requests from two masters, such as the processor core and a loader/DMA engine. It grants the port round-robin and drives the RAM's write enable, address and bidirectional data bus. It returns read data with a one-cycle acknowledge. The RAM's separate video read port is not touched by this block.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that sequences two masters onto the single read/write port
// of the 256x8 data RAM: one cycle of RAM access followed by a one-cycle acknowledge.
module mem_arbiter (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       req0_i,
    input  logic       wr0_i,
    input  logic [7:0] addr0_i,
    input  logic [7:0] wdata0_i,
    output logic       ack0_o,
    input  logic       req1_i,
    input  logic       wr1_i,
    input  logic [7:0] addr1_i,
    input  logic [7:0] wdata1_i,
    output logic       ack1_o,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       mem_we_o,
    output logic [7:0] mem_address_o,
    inout  wire  [7:0] mem_data_io
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t     state_q;
    logic       last_q;
    logic       winner_q;
    logic       wr_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       ack0_q;
    logic       ack1_q;
    logic       busy_q;
    logic       mem_we_q;
    logic       grant_d;

    logic [1:0] req_v;
    logic [1:0] wr_v;
    logic [7:0] addr_v  [2];
    logic [7:0] wdata_v [2];

    assign req_v      = {req1_i, req0_i};
    assign wr_v       = {wr1_i, wr0_i};
    assign addr_v[0]  = addr0_i;
    assign addr_v[1]  = addr1_i;
    assign wdata_v[0] = wdata0_i;
    assign wdata_v[1] = wdata1_i;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        grant_d = req_v[1];
        if (req_v == 2'b11) begin
            grant_d = ~last_q;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            winner_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    if (|req_v) begin
                        winner_q <= grant_d;
                        last_q   <= grant_d;
                        wr_q     <= wr_v[grant_d];
                        addr_q   <= addr_v[grant_d];
                        wdata_q  <= wdata_v[grant_d];
                        mem_we_q <= wr_v[grant_d];
                        busy_q   <= 1'b1;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    // RAM answers a read combinationally while we release the bus.
                    if (!wr_q) begin
                        rdata_q <= mem_data_io;
                    end
                    mem_we_q <= 1'b0;
                    ack0_q   <= ~winner_q;
                    ack1_q   <= winner_q;
                    state_q  <= ACK;
                end
                ACK: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Bus is driven exactly when the write enable is, so we never fight the RAM.
    for (genvar gi = 0; gi < 8; gi++) begin : g_bus
        assign mem_data_io[gi] = mem_we_q ? wdata_q[gi] : 1'bz;
    end

    assign ack0_o        = ack0_q;
    assign ack1_o        = ack1_q;
    assign rdata_o       = rdata_q;
    assign busy_o        = busy_q;
    assign mem_we_o      = mem_we_q;
    assign mem_address_o = addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level model of the arbiter and the RAM contents.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, wr0, req1, wr1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1, busy, mem_we;
    logic [7:0] rdata, mem_address;
    wire  [7:0] mem_data;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .req0_i        (req0),
        .wr0_i         (wr0),
        .addr0_i       (addr0),
        .wdata0_i      (wdata0),
        .ack0_o        (ack0),
        .req1_i        (req1),
        .wr1_i         (wr1),
        .addr1_i       (addr1),
        .wdata1_i      (wdata1),
        .ack1_o        (ack1),
        .rdata_o       (rdata),
        .busy_o        (busy),
        .mem_we_o      (mem_we),
        .mem_address_o (mem_address),
        .mem_data_io   (mem_data)
    );

    // Released bus reads as 0xFF; random write data avoids 0xFF so a stray drive shows.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (mem_data[gi]);
    end

    // Environment RAM: combinational read onto the bus, write at the clock edge.
    logic [7:0] ram [256];
    logic       ram_oe = 1'b0;
    assign mem_data = ram_oe ? ram[mem_address] : 8'bz;
    always @(posedge clk) begin
        if (mem_we) ram[mem_address] <= mem_data;
    end

    // Reference model: one outstanding transaction with an age (0 = RAM cycle, 1 = ack cycle).
    logic [7:0] model_mem [256];
    bit         m_valid = 0, m_age = 0, m_who = 0, m_wr = 0, m_last = 1;
    logic [7:0] m_addr = 0, m_wdata = 0, m_rdata = 0, m_laddr = 0;

    int n_pass = 0, n_total = 0, cyc = 0, we_cnt = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_step();
        if (m_valid && !m_age && m_wr) model_mem[m_addr] = m_wdata;
        if (rst) begin
            m_valid = 0; m_last = 1; m_rdata = 8'h00; m_laddr = 8'h00;
        end else if (m_valid) begin
            if (!m_age) begin
                if (!m_wr) m_rdata = model_mem[m_addr];
                m_age = 1;
            end else begin
                m_valid = 0;
            end
        end else if (req0 || req1) begin
            m_who   = (req0 && req1) ? !m_last : req1;
            m_last  = m_who;
            m_wr    = m_who ? wr1 : wr0;
            m_addr  = m_who ? addr1 : addr0;
            m_wdata = m_who ? wdata1 : wdata0;
            m_laddr = m_addr;
            m_valid = 1;
            m_age   = 0;
        end
    endtask

    task automatic tick();
        logic [7:0] exp_data;
        model_step();
        @(posedge clk);
        #1;
        ram_oe = m_valid && !m_age && !m_wr;
        @(negedge clk);
        cyc++;
        exp_data = (m_valid && !m_age) ? (m_wr ? m_wdata : model_mem[m_addr]) : 8'hFF;
        check("busy",        {7'b0, busy},   {7'b0, m_valid});
        check("mem_we",      {7'b0, mem_we}, {7'b0, m_valid && !m_age && m_wr});
        check("mem_address", mem_address,    m_laddr);
        check("ack0",        {7'b0, ack0},   {7'b0, m_valid && m_age && !m_who});
        check("ack1",        {7'b0, ack1},   {7'b0, m_valid && m_age && m_who});
        check("rdata",       rdata,          m_rdata);
        check("mem_data",    mem_data,       exp_data);
        if (mem_we) we_cnt++;
        if (ack0 || ack1)
            $display("txn cycle %0d: ack%0d rdata=%02h", cyc, ack1 ? 1 : 0, rdata);
    endtask

    task automatic do_req(input bit who, input bit wr, input logic [7:0] addr,
                          input logic [7:0] wdata, output int lat, output logic [7:0] rd);
        bit seen = 0;
        if (who) begin req1 = 1; wr1 = wr; addr1 = addr; wdata1 = wdata; end
        else     begin req0 = 1; wr0 = wr; addr0 = addr; wdata0 = wdata; end
        lat = 0;
        rd  = 8'h00;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            lat++;
            if ((who && ack1) || (!who && ack0)) begin seen = 1; rd = rdata; end
        end
        check("ack_seen", {7'b0, seen}, 8'h01);
        if (who) req1 = 0; else req0 = 0;
        tick();
    endtask

    task automatic raise(input int i);
        logic [7:0] d;
        d = 8'($urandom_range(0, 254));
        if (i == 1) begin
            req1 = 1; wr1 = 1'($urandom); addr1 = 8'($urandom_range(0, 15)); wdata1 = d;
        end else begin
            req0 = 1; wr0 = 1'($urandom); addr0 = 8'($urandom_range(0, 15)); wdata0 = d;
        end
    endtask

    initial begin
        int lat, prev_cyc, n_acks;
        logic [7:0] rd;
        bit found, prev_who, who, any_ack;

        for (int i = 0; i < 256; i++) begin
            ram[i]       = 8'($urandom);
            model_mem[i] = ram[i];
        end

        // Reset with both requests pending, then first grant must go to requester 0.
        rst = 1; req0 = 1; wr0 = 0; addr0 = 8'h01; wdata0 = 8'h11;
        req1 = 1; wr1 = 0; addr1 = 8'h02; wdata1 = 8'h22;
        tick();
        tick();
        rst = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ack0 || ack1) begin
                found = 1;
                check("first_winner", {6'b0, ack1, ack0}, 8'h01);
            end
        end
        check("first_ack_seen", {7'b0, found}, 8'h01);
        req0 = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ack1) found = 1;
        end
        check("second_ack_seen", {7'b0, found}, 8'h01);
        req1 = 0;
        tick();

        // Single read of a preloaded location.
        ram[8'h10] = 8'h5A; model_mem[8'h10] = 8'h5A;
        do_req(0, 0, 8'h10, 8'h00, lat, rd);
        check("read_latency", 8'(lat), 8'd2);
        check("read_data", rd, 8'h5A);

        // Write from requester 1, then read back through requester 0.
        we_cnt = 0;
        do_req(1, 1, 8'h20, 8'hC3, lat, rd);
        check("write_we_cycles", 8'(we_cnt), 8'd1);
        check("write_latency", 8'(lat), 8'd2);
        do_req(0, 0, 8'h20, 8'h00, lat, rd);
        check("readback", rd, 8'hC3);

        // Contention: both held high; grants alternate, three cycles apart.
        req0 = 1; wr0 = 0; addr0 = 8'h40; req1 = 1; wr1 = 0; addr1 = 8'h41;
        n_acks = 0; prev_cyc = 0; prev_who = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ack0 || ack1) begin
                who = ack1;
                if (n_acks > 0) begin
                    check("alternate", {7'b0, who}, {7'b0, !prev_who});
                    check("spacing", 8'(cyc - prev_cyc), 8'd3);
                end
                prev_who = who; prev_cyc = cyc; n_acks++;
            end
        end
        check("contention_acks", 8'(n_acks), 8'd10);
        req0 = 0; req1 = 0;
        repeat (3) tick();

        // Reset during the RAM cycle of a write: write lands, no ack.
        req0 = 1; wr0 = 1; addr0 = 8'h30; wdata0 = 8'h77;
        tick();
        check("midwr_we", {7'b0, mem_we}, 8'h01);
        rst = 1; req0 = 0;
        tick();
        rst = 0;
        any_ack = 0;
        repeat (3) begin
            tick();
            if (ack0 || ack1) any_ack = 1;
        end
        check("midwr_no_ack", {7'b0, any_ack}, 8'h00);
        check("midwr_idle", {7'b0, busy}, 8'h00);
        do_req(0, 0, 8'h30, 8'h00, lat, rd);
        check("midwr_readback", rd, 8'h77);

        // Random traffic with occasional resets.
        for (int c = 0; c < 1000; c++) begin
            if (!req0 && $urandom_range(0, 3) == 0) raise(0);
            if (!req1 && $urandom_range(0, 3) == 0) raise(1);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            if (ack0 && $urandom_range(0, 1) == 0) req0 = 0;
            if (ack1 && $urandom_range(0, 1) == 0) req1 = 0;
        end
        rst = 0; req0 = 0; req1 = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
